// File: rtl/alu_nibble_sequencer.sv
// alu_nibble_sequencer
//   Runs a WIDTH-bit ALU operation through one external 4-bit ALU slice,
//   one nibble per cycle, least-significant nibble first. It carries the
//   slice carry between cycles and resolves SLT, zero and overflow, which
//   the slice cannot do on its own.
//
// Ports
//   clk, reset            clock; synchronous active-high reset
//   in_valid/in_ready     request handshake (in_ready only in IDLE)
//   in_a, in_b, in_op     operands and op (000 AND, 001 OR, 010 ADD,
//                         110 SUB, 111 SLT; all other codes are illegal)
//   out_valid/out_ready   result handshake (out_valid only in DONE)
//   out_result            registered WIDTH-bit result
//   out_zero, out_cout,
//   out_ovf, out_illegal  registered result flags
//   slice_a/b/cin/less/op drive to the external slice (all 0 outside RUN)
//   slice_result/cout/set combinational answer from the slice
module alu_nibble_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_illegal,
    output logic [3:0]       slice_a,
    output logic [3:0]       slice_b,
    output logic             slice_cin,
    output logic             slice_less,
    output logic [2:0]       slice_op,
    input  logic [3:0]       slice_result,
    input  logic             slice_cout,
    input  logic             slice_set
);

    localparam int NNIB = WIDTH / 4;
    localparam int KW   = (NNIB > 1) ? $clog2(NNIB) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q;
    logic [2:0]       op_q;
    logic [KW-1:0]    k_q;
    logic             carry_q;

    logic             last;
    logic             legal, is_slt, is_addsub, is_arith;
    logic             ovf_int;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] final_res;

    assign last       = (k_q == KW'(NNIB - 1));
    assign slice_less = 1'b0;

    // Decode of the latched op.
    always_comb begin
        legal     = (op_q == 3'b000) || (op_q == 3'b001) || (op_q == 3'b010) ||
                    (op_q == 3'b110) || (op_q == 3'b111);
        is_slt    = (op_q == 3'b111);
        is_addsub = (op_q == 3'b010) || (op_q == 3'b110);
        is_arith  = is_addsub || is_slt;
    end

    // State machine: next state and handshake outputs.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = S_RUN;
            end
            S_RUN: begin
                if (last) state_d = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Slice drive; SLT runs as a subtract, illegal ops as a harmless AND.
    always_comb begin
        slice_a   = 4'd0;
        slice_b   = 4'd0;
        slice_cin = 1'b0;
        slice_op  = 3'b000;
        if (state_q == S_RUN) begin
            slice_a   = a_q[4*int'(k_q) +: 4];
            slice_b   = b_q[4*int'(k_q) +: 4];
            slice_cin = (k_q == '0) ? op_q[2] : carry_q;
            slice_op  = !legal ? 3'b000 : (is_slt ? 3'b110 : op_q);
        end
    end

    // Result resolution. The signed-overflow test uses the effective B sign
    // (inverted for subtract) against the slice's final sum MSB; SLT is the
    // sign of the difference corrected by that overflow.
    always_comb begin
        acc                       = out_result;
        acc[4*int'(k_q) +: 4]     = slice_result;
        ovf_int   = (a_q[WIDTH-1] == (b_q[WIDTH-1] ^ op_q[2])) &&
                    (slice_set != a_q[WIDTH-1]);
        final_res = acc;
        if (!legal)
            final_res = '0;
        else if (is_slt)
            final_res = {{(WIDTH-1){1'b0}}, slice_set ^ ovf_int};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            k_q         <= '0;
            carry_q     <= 1'b0;
            out_result  <= '0;
            out_zero    <= 1'b0;
            out_cout    <= 1'b0;
            out_ovf     <= 1'b0;
            out_illegal <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q         <= in_a;
                        b_q         <= in_b;
                        op_q        <= in_op;
                        k_q         <= '0;
                        carry_q     <= 1'b0;
                        out_result  <= '0;
                        out_zero    <= 1'b0;
                        out_cout    <= 1'b0;
                        out_ovf     <= 1'b0;
                        out_illegal <= 1'b0;
                    end
                end
                S_RUN: begin
                    carry_q <= slice_cout;
                    k_q     <= last ? '0 : k_q + KW'(1);
                    if (last) begin
                        out_result  <= final_res;
                        out_zero    <= (final_res == '0);
                        out_cout    <= legal && is_arith && slice_cout;
                        out_ovf     <= legal && is_addsub && ovf_int;
                        out_illegal <= !legal;
                    end else begin
                        out_result  <= acc;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
module tb_alu_nibble_sequencer;

    localparam int WIDTH = 16;
    localparam int NNIB  = WIDTH / 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a, in_b;
    logic [2:0]       in_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_zero, out_cout, out_ovf, out_illegal;
    logic [3:0]       slice_a, slice_b;
    logic             slice_cin, slice_less;
    logic [2:0]       slice_op;
    logic [3:0]       slice_result;
    logic             slice_cout, slice_set;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_nibble_sequencer #(.WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_zero(out_zero), .out_cout(out_cout),
        .out_ovf(out_ovf), .out_illegal(out_illegal),
        .slice_a(slice_a), .slice_b(slice_b), .slice_cin(slice_cin),
        .slice_less(slice_less), .slice_op(slice_op),
        .slice_result(slice_result), .slice_cout(slice_cout), .slice_set(slice_set)
    );

    // External 4-bit ALU slice.
    logic [4:0] sum5;
    always_comb begin
        sum5         = {1'b0, slice_a} + {1'b0, (slice_op[2] ? ~slice_b : slice_b)} + {4'd0, slice_cin};
        slice_set    = sum5[3];
        slice_result = 4'd0;
        slice_cout   = 1'b0;
        case (slice_op)
            3'b000: slice_result = slice_a & slice_b;
            3'b001: slice_result = slice_a | slice_b;
            3'b010, 3'b110: begin
                slice_result = sum5[3:0];
                slice_cout   = sum5[4];
            end
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Whole-word reference built from arithmetic on the operands.
    task automatic model(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op,
                         output logic [15:0] res, output logic z, output logic c,
                         output logic v, output logic ill);
        logic [16:0] full;
        res = 16'd0; c = 1'b0; v = 1'b0; ill = 1'b0;
        case (op)
            3'b000: res = a & b;
            3'b001: res = a | b;
            3'b010: begin
                full = {1'b0, a} + {1'b0, b};
                res  = full[15:0];
                c    = full[16];
                v    = (a[15] == b[15]) && (res[15] != a[15]);
            end
            3'b110: begin
                full = {1'b0, a} - {1'b0, b};
                res  = full[15:0];
                c    = (a >= b);   // no borrow == carry out of a + ~b + 1
                v    = (a[15] != b[15]) && (res[15] != a[15]);
            end
            3'b111: begin
                res = ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
                c   = (a >= b);
            end
            default: ill = 1'b1;
        endcase
        z = (res == 16'd0);
    endtask

    // Accept a request, measure latency and check the DONE outputs.
    task automatic start_op(input logic [15:0] a, input logic [15:0] b,
                            input logic [2:0] op, input string tag);
        logic [15:0] er;
        logic ez, ec, ev, ei;
        logic [2:0] eop;
        int lat;
        int guard;
        model(a, b, op, er, ez, ec, ev, ei);
        guard = 0;
        while (!in_ready && guard < 20) begin step(); guard++; end
        check({tag, "_ready_wait"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_a = a; in_b = b; in_op = op;
        step();
        in_valid = 1'b0;
        eop = ei ? 3'b000 : ((op == 3'b111) ? 3'b110 : op);
        check({tag, "_in_ready_run"}, 32'(in_ready), 32'd0);
        check({tag, "_slice_op"}, 32'(slice_op), 32'(eop));
        check({tag, "_slice_a0"}, 32'(slice_a), 32'(a[3:0]));
        lat = 0;
        while (!out_valid && lat < 40) begin step(); lat++; end
        check({tag, "_latency"}, 32'(lat), 32'(NNIB));
        check({tag, "_result"}, 32'(out_result), 32'(er));
        check({tag, "_flags"}, {28'd0, out_zero, out_cout, out_ovf, out_illegal},
              {28'd0, ez, ec, ev, ei});
        check({tag, "_slice_idle"}, {23'd0, slice_a, slice_b, slice_cin}, 32'd0);
    endtask

    task automatic finish_op(input string tag);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
        check({tag, "_back_idle"}, 32'(in_ready), 32'd1);
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  op;
        string       tag;
    } vec_t;

    vec_t dir[8];

    initial begin
        logic [15:0] held;
        logic        seen;
        logic [2:0]  rop;

        reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; out_ready = 1'b0;
        step(); step();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", 32'(out_result), 32'd0);
        check("rst_flags", {28'd0, out_zero, out_cout, out_ovf, out_illegal}, 32'd0);
        check("rst_slice", {20'd0, slice_a, slice_b, slice_cin, slice_op}, 32'd0);
        reset = 1'b0;
        step();

        dir[0] = '{16'h00FF, 16'h0001, 3'b010, "add_carry"};
        dir[1] = '{16'h8000, 16'h0001, 3'b110, "sub_ovf"};
        dir[2] = '{16'h1234, 16'h1234, 3'b110, "sub_zero"};
        dir[3] = '{16'hFFFF, 16'h0001, 3'b111, "slt_neg"};
        dir[4] = '{16'h7FFF, 16'h8000, 3'b111, "slt_ovf"};
        dir[5] = '{16'hF0F0, 16'h3C3C, 3'b000, "and"};
        dir[6] = '{16'hF0F0, 16'h3C3C, 3'b001, "or"};
        dir[7] = '{16'hABCD, 16'h1111, 3'b011, "illegal"};
        foreach (dir[i]) begin
            start_op(dir[i].a, dir[i].b, dir[i].op, dir[i].tag);
            finish_op(dir[i].tag);
        end

        // Hold in DONE with a competing request pending.
        start_op(16'h0F0F, 16'h00FF, 3'b000, "hold");
        held = out_result;
        in_valid = 1'b1; in_a = 16'h1111; in_b = 16'h2222; in_op = 3'b010;
        for (int i = 0; i < 5; i++) begin
            step();
            check("hold_result", 32'(out_result), 32'(held));
            check("hold_valid_ready", {30'd0, out_valid, in_ready}, 32'd2);
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        step();
        out_ready = 1'b0;
        check("hold_not_consumed", {30'd0, out_valid, in_ready}, 32'd1);
        start_op(16'h1111, 16'h2222, 3'b010, "after_hold");
        finish_op("after_hold");

        // Reset while RUN is at nibble 2.
        in_valid = 1'b1; in_a = 16'h5555; in_b = 16'h1234; in_op = 3'b110;
        step();
        in_valid = 1'b0;
        step(); step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midrst_idle", 32'(in_ready), 32'd1);
        check("midrst_regs", {11'd0, out_result, out_valid, out_zero, out_cout, out_ovf, out_illegal}, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (out_valid) seen = 1'b1;
        end
        check("midrst_no_valid", 32'(seen), 32'd0);

        // Random operations, illegal codes included.
        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(7));
            start_op(16'($urandom), 16'($urandom), rop, "rand");
            if ($urandom_range(1) == 1) step();
            finish_op("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
